regfile: RTL

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_if.sv | 24 ++
 rtl/regfile.sv | 60 ++++++
 2 files changed

// File: rtl/regfile_if.sv
// Read/write bus between decode/write-back and the register file.
// The master drives requests; the slave returns read data and sweep status.
interface regfile_if;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        init_busy_o;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, init_busy_o
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2, init_busy_o
  );
endinterface

// File: rtl/regfile.sv
// 32x32 register file, 2 combinational read ports, 1 write port; r0 hardwired to zero.
// Writes land on the clock edge; after reset a 31-cycle sweep clears r1..r31 (no backpressure,
// writes during the sweep are dropped). Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t      state;
  logic [4:0]  ptr;
  logic [31:0] regs [32];

  // Index 0 is never written; reads of r0 are masked to zero below.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= 5'd1;
    end else begin
      case (state)
        CLEAR: begin
          regs[ptr] <= 32'h0;
          ptr       <= ptr + 5'd1;
          if (ptr == 5'd31) state <= READY;
        end
        READY: begin
          if (bus.we && bus.waddr != 5'd0) regs[bus.waddr] <= bus.wdata;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  function automatic logic [31:0] read_port(
    input logic        en,
    input logic [4:0]  addr,
    input logic [31:0] stored
  );
    logic [31:0] val;
    val = stored;
`ifdef REGFILE_BYPASS_EN
    if (bus.we && bus.waddr == addr) val = bus.wdata;
`endif
    if (rst || state != READY || !en || addr == 5'd0) val = 32'h0;
    return val;
  endfunction

  always_comb begin
    bus.rdata1 = read_port(bus.re1, bus.raddr1, regs[bus.raddr1]);
  end

  always_comb begin
    bus.rdata2 = read_port(bus.re2, bus.raddr2, regs[bus.raddr2]);
  end

  assign bus.init_busy_o = rst || (state == CLEAR);

endmodule
